mul_div_control_seq: RTL and testbench

//  Hardwired control sequencer for the datapath: fetches an instruction, then steps one register-register
//  MUL or DIV through T0..T6, driving the datapath's Rout/Rin, Yin, Zin, HIin and LOin strobes.

---
 rtl/cpu_ctrl_pkg.sv | 54 +++++
 rtl/ctrl_wait_counter.sv | 32 +++
 rtl/mul_div_control_seq.sv | 169 ++++++++++++++++
 tb/tb_mul_div_control_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the MUL/DIV control sequencer: opcodes, IR field positions,
// state encoding and the datapath strobe bundle.
package cpu_ctrl_pkg;

    localparam logic [4:0] OPC_MUL = 5'b10000;
    localparam logic [4:0] OPC_DIV = 5'b01111;

    localparam int IR_OPC_HI = 31;
    localparam int IR_OPC_LO = 27;
    localparam int IR_RA_HI  = 26;
    localparam int IR_RA_LO  = 23;
    localparam int IR_RB_HI  = 22;
    localparam int IR_RB_LO  = 19;

    // State values double as the step debug code.
    typedef enum logic [3:0] {
        ST_T0     = 4'd0,
        ST_T1     = 4'd1,
        ST_T2     = 4'd2,
        ST_T3     = 4'd3,
        ST_T4     = 4'd4,
        ST_T5     = 4'd5,
        ST_T6     = 4'd6,
        HALT_IDLE = 4'hF
    } ctrl_state_e;

    typedef struct packed {
        logic r_in;
        logic r_out;
        logic grb;
        logic gra;
        logic div;
        logic mul;
        logic lo_in;
        logic hi_in;
        logic y_in;
        logic ir_in;
        logic mdr_out;
        logic mdr_in;
        logic read;
        logic pc_in;
        logic z_high_out;
        logic z_low_out;
        logic z_in;
        logic inc_pc;
        logic mar_in;
        logic pc_out;
    } ctrl_strobes_t;

    function automatic logic is_legal_opc(input logic [4:0] opc);
        return (opc == OPC_MUL) || (opc == OPC_DIV);
    endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// Small load/decrement counter with a zero flag; paces the T1 memory wait.
module ctrl_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == 4'd0);

endmodule

// File: rtl/mul_div_control_seq.sv
// Hardwired fetch + MUL/DIV sequencer: steps T0..T6 and drives registered datapath strobes.
module mul_div_control_seq
    import cpu_ctrl_pkg::*;
#(
    parameter logic [3:0] MEM_WAIT = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic        alu_done,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        MUL,
    output logic        DIV,
    output logic        Gra,
    output logic        Grb,
    output logic        Rout,
    output logic        Rin,
    output logic [3:0]  step,
    output logic        illegal
);

    ctrl_state_e   state_q, state_d;
    ctrl_strobes_t strb_q, strb_d;
    logic [4:0]    opc_q, opc_d;
    logic          illegal_q, illegal_d;
    logic          fetch_q, fetch_d;
    logic [3:0]    step_q, step_d;
    logic          cnt_load, cnt_dec, cnt_zero;
    logic          unused_ir;

    assign unused_ir = ^{IR[IR_RA_HI:IR_RA_LO], IR[IR_RB_HI:IR_RB_LO], IR[IR_RB_LO-1:0]};

    ctrl_wait_counter u_wait (
        .clk      (clk),
        .rst_n    (reset),
        .load     (cnt_load),
        .load_val (MEM_WAIT),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        illegal_d = illegal_q;
        fetch_d   = fetch_q;
        cnt_dec   = 1'b0;
        case (state_q)
            HALT_IDLE: if (run && !illegal_q) state_d = ST_T0;
            ST_T0:     state_d = fetch_q ? ST_T1 : HALT_IDLE;
            ST_T1: begin
                if (cnt_zero) state_d = ST_T2;
                else          cnt_dec = 1'b1;
            end
            ST_T2: begin
                state_d = ST_T3;
                opc_d   = IR[IR_OPC_HI:IR_OPC_LO];
                if (!is_legal_opc(IR[IR_OPC_HI:IR_OPC_LO])) illegal_d = 1'b1;
            end
            ST_T3:     state_d = is_legal_opc(opc_q) ? ST_T4 : HALT_IDLE;
            ST_T4:     if ((opc_q == OPC_MUL) || alu_done) state_d = ST_T5;
            ST_T5:     state_d = ST_T6;
            ST_T6:     state_d = ST_T0;
            default:   state_d = HALT_IDLE;
        endcase

        // run is judged on the edge into T0; a dropped run gives one silent T0 then halt.
        if ((state_d == ST_T0) && (state_q != ST_T0)) fetch_d = run;
        cnt_load = (state_d == ST_T1) && (state_q != ST_T1);

        strb_d = '0;
        case (state_d)
            ST_T0: begin
                strb_d.pc_out = fetch_d;
                strb_d.mar_in = fetch_d;
                strb_d.inc_pc = fetch_d;
                strb_d.z_in   = fetch_d;
            end
            ST_T1: begin
                strb_d.z_low_out = 1'b1;
                strb_d.pc_in     = (state_q != ST_T1);
                strb_d.read      = 1'b1;
                strb_d.mdr_in    = 1'b1;
            end
            ST_T2: begin
                strb_d.mdr_out = 1'b1;
                strb_d.ir_in   = 1'b1;
            end
            ST_T3: begin
                strb_d.gra   = is_legal_opc(opc_d);
                strb_d.r_out = is_legal_opc(opc_d);
                strb_d.y_in  = is_legal_opc(opc_d);
            end
            ST_T4: begin
                strb_d.grb   = 1'b1;
                strb_d.r_out = 1'b1;
                strb_d.z_in  = 1'b1;
                strb_d.mul   = (opc_d == OPC_MUL);
                strb_d.div   = (opc_d == OPC_DIV);
            end
            ST_T5: begin
                strb_d.z_low_out = 1'b1;
                strb_d.lo_in     = 1'b1;
            end
            ST_T6: begin
                strb_d.z_high_out = 1'b1;
                strb_d.hi_in      = 1'b1;
            end
            default: ;
        endcase
        step_d = state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= HALT_IDLE;
            strb_q    <= '0;
            opc_q     <= 5'd0;
            illegal_q <= 1'b0;
            fetch_q   <= 1'b0;
            step_q    <= 4'hF;
        end else begin
            state_q   <= state_d;
            strb_q    <= strb_d;
            opc_q     <= opc_d;
            illegal_q <= illegal_d;
            fetch_q   <= fetch_d;
            step_q    <= step_d;
        end
    end

    assign PCout    = strb_q.pc_out;
    assign MARin    = strb_q.mar_in;
    assign IncPC    = strb_q.inc_pc;
    assign Zin      = strb_q.z_in;
    assign Zlowout  = strb_q.z_low_out;
    assign Zhighout = strb_q.z_high_out;
    assign PCin     = strb_q.pc_in;
    assign Read     = strb_q.read;
    assign MDRin    = strb_q.mdr_in;
    assign MDRout   = strb_q.mdr_out;
    assign IRin     = strb_q.ir_in;
    assign Yin      = strb_q.y_in;
    assign HIin     = strb_q.hi_in;
    assign LOin     = strb_q.lo_in;
    assign MUL      = strb_q.mul;
    assign DIV      = strb_q.div;
    assign Gra      = strb_q.gra;
    assign Grb      = strb_q.grb;
    assign Rout     = strb_q.r_out;
    assign Rin      = strb_q.r_in;
    assign step     = step_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_mul_div_control_seq.sv
// Bench for mul_div_control_seq: per-cycle strobe trace plus a datapath stub for HI/LO/PC results.
module tb_mul_div_control_seq;

    // Observation word: {illegal, step[3:0], strobes[19:0]} with PCout at bit 0.
    localparam logic [19:0] S_PCOUT = 20'd1 << 0,  S_MARIN = 20'd1 << 1,  S_INCPC = 20'd1 << 2;
    localparam logic [19:0] S_ZIN   = 20'd1 << 3,  S_ZLOW  = 20'd1 << 4,  S_ZHIGH = 20'd1 << 5;
    localparam logic [19:0] S_PCIN  = 20'd1 << 6,  S_READ  = 20'd1 << 7,  S_MDRIN = 20'd1 << 8;
    localparam logic [19:0] S_MDROUT = 20'd1 << 9, S_IRIN  = 20'd1 << 10, S_YIN   = 20'd1 << 11;
    localparam logic [19:0] S_HIIN  = 20'd1 << 12, S_LOIN  = 20'd1 << 13, S_MUL   = 20'd1 << 14;
    localparam logic [19:0] S_DIV   = 20'd1 << 15, S_GRA   = 20'd1 << 16, S_GRB   = 20'd1 << 17;
    localparam logic [19:0] S_ROUT  = 20'd1 << 18;
    localparam logic [24:0] RESET_OBS = 25'h0F00000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        sel = 1'b0;
    logic        alu_done = 1'b0;
    logic [31:0] ir = 32'd0;
    logic [24:0] obs0, obs3;
    wire  [24:0] obs = sel ? obs3 : obs0;
    wire         run0 = run & ~sel;
    wire         run3 = run & sel;

    int checks = 0;
    int errors = 0;
    logic        m_ill = 1'b0;
    logic [24:0] exp_q[$];
    logic [33:0] drv_q[$];

    logic [31:0] regs [16];
    logic [31:0] dp_y = 0, dp_pc = 0, dp_hi = 0, dp_lo = 0;
    logic [63:0] dp_z = 0;

    typedef struct {
        logic [31:0] ir;
        bit          sel3;
        int          dl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    mul_div_control_seq #(.MEM_WAIT(4'd0)) u_dut0 (
        .clk(clk), .reset(reset), .run(run0), .IR(ir), .alu_done(alu_done),
        .PCout(obs0[0]), .MARin(obs0[1]), .IncPC(obs0[2]), .Zin(obs0[3]), .Zlowout(obs0[4]),
        .Zhighout(obs0[5]), .PCin(obs0[6]), .Read(obs0[7]), .MDRin(obs0[8]), .MDRout(obs0[9]),
        .IRin(obs0[10]), .Yin(obs0[11]), .HIin(obs0[12]), .LOin(obs0[13]), .MUL(obs0[14]),
        .DIV(obs0[15]), .Gra(obs0[16]), .Grb(obs0[17]), .Rout(obs0[18]), .Rin(obs0[19]),
        .step(obs0[23:20]), .illegal(obs0[24])
    );

    mul_div_control_seq #(.MEM_WAIT(4'd3)) u_dut3 (
        .clk(clk), .reset(reset), .run(run3), .IR(ir), .alu_done(alu_done),
        .PCout(obs3[0]), .MARin(obs3[1]), .IncPC(obs3[2]), .Zin(obs3[3]), .Zlowout(obs3[4]),
        .Zhighout(obs3[5]), .PCin(obs3[6]), .Read(obs3[7]), .MDRin(obs3[8]), .MDRout(obs3[9]),
        .IRin(obs3[10]), .Yin(obs3[11]), .HIin(obs3[12]), .LOin(obs3[13]), .MUL(obs3[14]),
        .DIV(obs3[15]), .Gra(obs3[16]), .Grb(obs3[17]), .Rout(obs3[18]), .Rin(obs3[19]),
        .step(obs3[23:20]), .illegal(obs3[24])
    );

    // Datapath stub reacting to the selected sequencer's strobes.
    always @(posedge clk) begin : datapath
        logic [31:0] bus;
        longint a, b;
        bus = regs[obs[16] ? ir[26:23] : ir[22:19]];
        a = longint'($signed(dp_y));
        b = longint'($signed(bus));
        if (obs[18] && obs[11]) dp_y <= bus;
        if (obs[3]) begin
            if (obs[14])                dp_z <= 64'(a * b);
            else if (obs[15] && b != 0) dp_z <= {32'(a % b), 32'(a / b)};
            else if (obs[2])            dp_z <= {32'd0, dp_pc + 32'd1};
        end
        if (obs[4] && obs[6])  dp_pc <= dp_z[31:0];
        if (obs[4] && obs[13]) dp_lo <= dp_z[31:0];
        if (obs[5] && obs[12]) dp_hi <= dp_z[63:32];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic a, input logic [31:0] iv,
                        input logic [3:0] st, input logic [19:0] strb);
        drv_q.push_back({r, a, iv});
        exp_q.push_back({m_ill, st, strb});
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push_start(input logic [31:0] iv);
        push(1'b1, rnd(), iv, 4'hF, 20'd0);
    endtask

    task automatic push_stop();
        push(1'b0, rnd(), 32'd0, 4'd0, 20'd0);
        push(1'b0, rnd(), 32'd0, 4'hF, 20'd0);
    endtask

    // Expected trace of one instruction from T0; run_late is driven from T3 onward.
    task automatic push_instr(input logic [31:0] iv, input int w, input int dl, input logic run_late);
        logic [4:0] op;
        op = iv[31:27];
        push(1'b1, rnd(), iv, 4'd0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN);
        for (int i = 0; i <= w; i++)
            push(1'b1, rnd(), iv, 4'd1, S_ZLOW | S_READ | S_MDRIN | ((i == 0) ? S_PCIN : 20'd0));
        push(1'b1, rnd(), iv, 4'd2, S_MDROUT | S_IRIN);
        if (op != 5'b10000 && op != 5'b01111) begin
            m_ill = 1'b1;
            push(run_late, rnd(), iv, 4'd3, 20'd0);
            return;
        end
        push(run_late, rnd(), iv, 4'd3, S_GRA | S_ROUT | S_YIN);
        if (op == 5'b01111) begin
            for (int k = 0; k <= dl; k++)
                push(run_late, (k >= dl), iv, 4'd4, S_GRB | S_ROUT | S_ZIN | S_DIV);
        end else begin
            push(run_late, rnd(), iv, 4'd4, S_GRB | S_ROUT | S_ZIN | S_MUL);
        end
        push(run_late, rnd(), iv, 4'd5, S_ZLOW | S_LOIN);
        push(run_late, rnd(), iv, 4'd6, S_ZHIGH | S_HIIN);
    endtask

    task automatic drain(input int n);
        logic [33:0] d;
        int done = 0;
        while (drv_q.size() > 0 && (n < 0 || done < n)) begin
            d = drv_q.pop_front();
            @(posedge clk);
            #1;
            run = d[33];
            alu_done = d[32];
            ir = d[31:0];
            @(negedge clk);
            check("cycle", 64'(obs), 64'(exp_q.pop_front()));
            done++;
        end
    endtask

    task automatic run_one(input logic [31:0] iv, input bit s3, input int dl,
                           input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] pc0;
        sel = s3;
        pc0 = dp_pc;
        push_start(iv);
        push_instr(iv, s3 ? 3 : 0, dl, 1'b0);
        push_stop();
        drain(-1);
        check("hi", 64'(dp_hi), 64'(ehi));
        check("lo", 64'(dp_lo), 64'(elo));
        check("pc_inc", 64'(dp_pc), 64'(pc0 + 32'd1));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        run = 1'b0;
        #1;
        check("reset_obs0", 64'(obs0), 64'(RESET_OBS));
        check("reset_obs3", 64'(obs3), 64'(RESET_OBS));
        m_ill = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] hi0, lo0, pc0, iv, av, bv, ehi, elo;
        logic [3:0] ra, rb;
        longint x, y, p;
        bit isdiv;

        for (int i = 0; i < 16; i++) regs[i] = 32'd0;
        tbl[0] = '{32'h81300000, 1'b0, 0, 32'd55, 32'hFFFFFFE0, 32'hFFFFFFFF, 32'hFFFFF920};
        tbl[1] = '{32'h79300000, 1'b0, 3, 32'd55, 32'hFFFFFFE0, 32'h00000017, 32'hFFFFFFFF};
        tbl[2] = '{32'h81300000, 1'b1, 0, 32'd55, 32'hFFFFFFE0, 32'hFFFFFFFF, 32'hFFFFF920};
        tbl[3] = '{32'h79300000, 1'b1, 0, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2};
        tbl[4] = '{32'h81980000, 1'b0, 1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        repeat (3) @(posedge clk);
        #1;
        check("reset_obs0", 64'(obs0), 64'(RESET_OBS));
        check("reset_obs3", 64'(obs3), 64'(RESET_OBS));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            regs[tbl[i].ir[26:23]] = tbl[i].a;
            regs[tbl[i].ir[22:19]] = tbl[i].b;
            run_one(tbl[i].ir, tbl[i].sel3, tbl[i].dl, tbl[i].hi, tbl[i].lo);
        end

        // Back-to-back MUL then DIV; run dropped from T3 of the DIV onward.
        regs[2] = 32'd55; regs[6] = 32'hFFFFFFE0; regs[4] = 32'd1000; regs[5] = 32'hFFFFFFF9;
        sel = 1'b0;
        pc0 = dp_pc;
        push_start(32'h81300000);
        push_instr(32'h81300000, 0, 0, 1'b1);
        push_instr(32'h7A280000, 0, 2, 1'b0);
        push_stop();
        drain(-1);
        check("b2b_hi", 64'(dp_hi), 64'd6);
        check("b2b_lo", 64'(dp_lo), 64'(32'hFFFFFF72));
        check("b2b_pc", 64'(dp_pc), 64'(pc0 + 32'd2));

        for (int n = 0; n < 10; n++) begin
            isdiv = 1'($urandom_range(0, 1));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            av = 32'($signed($urandom_range(0, 4000)) - 2000);
            bv = 32'($signed($urandom_range(0, 4000)) - 2000);
            if (bv == 32'd0) bv = 32'd3;
            if (av == 32'd0) av = 32'd5;
            regs[ra] = av;
            regs[rb] = bv;
            x = longint'($signed(regs[ra]));
            y = longint'($signed(regs[rb]));
            if (isdiv) begin
                ehi = 32'(x % y);
                elo = 32'(x / y);
            end else begin
                p = x * y;
                ehi = p[63:32];
                elo = p[31:0];
            end
            iv = {isdiv ? 5'b01111 : 5'b10000, ra, rb, 19'($urandom)};
            run_one(iv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), ehi, elo);
        end

        // Reset in the middle of a long DIV wait.
        regs[2] = 32'd55; regs[6] = 32'hFFFFFFE0;
        sel = 1'b0;
        push_start(32'h79300000);
        push_instr(32'h79300000, 0, 10, 1'b1);
        drain(8);
        drv_q.delete();
        exp_q.delete();
        hi0 = dp_hi;
        lo0 = dp_lo;
        pulse_reset();
        check("rst_hi_kept", 64'(dp_hi), 64'(hi0));
        check("rst_lo_kept", 64'(dp_lo), 64'(lo0));

        // Illegal opcode: flags, then stays idle even with run held high.
        iv = 32'h18000000 | 32'($urandom_range(0, 32'h7FFFF));
        hi0 = dp_hi;
        lo0 = dp_lo;
        push_start(iv);
        push_instr(iv, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) push(1'b1, rnd(), iv, 4'hF, 20'd0);
        drain(-1);
        check("ill_hi_kept", 64'(dp_hi), 64'(hi0));
        check("ill_lo_kept", 64'(dp_lo), 64'(lo0));
        pulse_reset();

        regs[2] = 32'd55; regs[6] = 32'hFFFFFFE0;
        run_one(32'h81300000, 1'b0, 0, 32'hFFFFFFFF, 32'hFFFFF920);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
